// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the cache-to-RAM arbiter.
// Arbiter FSM states are plain logic constants so older encodings remain valid.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t D_ACC = 2'd1;
  localparam arb_state_t I_ACC = 2'd2;

  localparam int CNT_W = 4;

  // Saturating increment used by the starvation counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between dcache (read/write) and icache (read only).
// dcache wins by priority; icache is forced after STARVE_LIMIT back-to-back dcache grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_err
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             mem_err_q, mem_err_d;
  logic             d_req;
  logic             granted;

  assign d_req   = dREN | dWEN;
  assign granted = (state_q == D_ACC) || (state_q == I_ACC);
  assign mem_err = mem_err_q;

  // RAM outputs decode straight from state_q so an async reset drops them at once.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    mem_err_d = mem_err_q | (granted && (ramstate == ERROR));
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;

    case (state_q)
      IDLE: begin
        if (iREN && (starve_q == LIMIT)) begin
          state_d = I_ACC;
        end else if (d_req) begin
          state_d = D_ACC;
        end else if (iREN) begin
          state_d = I_ACC;
        end
      end

      D_ACC: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!d_req) begin
          // Abandoned request: no completion and the streak is left untouched.
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait    = 1'b0;
          dload    = ramload;
          state_d  = IDLE;
          starve_d = iREN ? sat_inc(starve_q, LIMIT) : '0;
        end
      end

      I_ACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          iwait    = 1'b0;
          iload    = ramload;
          state_d  = IDLE;
          starve_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      mem_err_q <= mem_err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level model of who owns the RAM port.
module tb_mem_arbiter;

  localparam int LIMIT = 4;
  localparam logic [1:0] RS_BUSY = 2'd1;
  localparam logic [1:0] RS_ACC  = 2'd2;
  localparam logic [1:0] RS_ERR  = 2'd3;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owner 0 = nobody, 1 = dcache, 2 = icache; streak = dcache wins while icache waited.
  int m_owner;
  int m_streak;
  bit m_err;

  logic [23:0] seq;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic        e_ren, e_wen, e_iw, e_dw, done;
    logic [31:0] e_addr, e_store, e_il, e_dl;
    e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1;
    e_addr = 0; e_store = 0; e_il = 0; e_dl = 0;
    if (m_owner == 1) begin
      e_wen   = dWEN;
      e_ren   = dREN && !dWEN;
      e_addr  = daddr;
      e_store = dstore;
      done    = (dREN || dWEN) && (ramstate == RS_ACC);
      e_dw    = !done;
      e_dl    = done ? ramload : 32'h0;
    end else if (m_owner == 2) begin
      e_ren  = 1;
      e_addr = iaddr;
      done   = iREN && (ramstate == RS_ACC);
      e_iw   = !done;
      e_il   = done ? ramload : 32'h0;
    end
    chk1 ("ramREN",   ramREN,   e_ren);
    chk1 ("ramWEN",   ramWEN,   e_wen);
    chk32("ramaddr",  ramaddr,  e_addr);
    chk32("ramstore", ramstore, e_store);
    chk1 ("iwait",    iwait,    e_iw);
    chk1 ("dwait",    dwait,    e_dw);
    chk32("iload",    iload,    e_il);
    chk32("dload",    dload,    e_dl);
    chk1 ("mem_err",  mem_err,  m_err);
  endtask

  task automatic model_update();
    if (m_owner != 0 && ramstate == RS_ERR) m_err = 1;
    case (m_owner)
      0: begin
        if (iREN && m_streak == LIMIT) m_owner = 2;
        else if (dREN || dWEN)         m_owner = 1;
        else if (iREN)                 m_owner = 2;
      end
      1: begin
        if (!(dREN || dWEN)) m_owner = 0;
        else if (ramstate == RS_ACC) begin
          m_streak = iREN ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
          m_owner  = 0;
        end
      end
      default: begin
        if (!iREN) m_owner = 0;
        else if (ramstate == RS_ACC) begin
          m_streak = 0;
          m_owner  = 0;
        end
      end
    endcase
  endtask

  task automatic model_reset();
    m_owner = 0; m_streak = 0; m_err = 0;
  endtask

  // Inputs are applied at a falling edge; outputs are checked 1 time unit later.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic quiet();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
  endtask

  initial begin
    quiet();
    nRST = 1'b0;
    model_reset();
    seq = '0;
    @(negedge CLK);
    #1;
    check_outputs();
    @(negedge CLK);
    nRST = 1'b1;

    // Read with two BUSY cycles before ACCESS.
    dREN = 1; daddr = 32'h40; ramstate = RS_BUSY;
    cycle();
    cycle();
    cycle();
    ramstate = RS_ACC; ramload = 32'hDEADBEEF;
    #1;
    chk1 ("t1 dwait pulse", dwait, 1'b0);
    chk32("t1 dload", dload, 32'hDEADBEEF);
    cycle();
    dREN = 0; ramstate = 2'd0;
    cycle();

    // Both caches hammering with an always-ready RAM.
    dREN = 1; iREN = 1; daddr = 32'h100; iaddr = 32'h200;
    ramstate = RS_ACC; ramload = 32'h0BADF00D;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (!dwait)      seq = {seq[19:0], 4'hD};
      else if (!iwait) seq = {seq[19:0], 4'h1};
      cycle();
    end
    chk32("t2 grant order", {8'h0, seq}, {8'h0, 24'hDDDD1D});
    quiet();
    cycle();

    // Write with BUSY before ACCESS.
    dWEN = 1; daddr = 32'h3100; dstore = 32'h12345678; ramstate = RS_BUSY;
    cycle();
    #1;
    chk1 ("t3 ramWEN", ramWEN, 1'b1);
    chk1 ("t3 ramREN", ramREN, 1'b0);
    chk32("t3 ramaddr", ramaddr, 32'h3100);
    chk32("t3 ramstore", ramstore, 32'h12345678);
    cycle();
    cycle();
    ramstate = RS_ACC;
    #1;
    chk1("t3 dwait done", dwait, 1'b0);
    cycle();
    quiet();
    cycle();

    // dcache abandons its request mid-access; the waiting icache then goes.
    dREN = 1; iREN = 1; daddr = 32'h700; iaddr = 32'h800; ramstate = RS_BUSY;
    cycle();
    cycle();
    dREN = 0;
    cycle();
    cycle();
    ramstate = RS_ACC; ramload = 32'h55AA55AA;
    #1;
    chk1 ("t4 iwait done", iwait, 1'b0);
    chk32("t4 iload", iload, 32'h55AA55AA);
    cycle();
    quiet();
    cycle();

    // RAM error during an icache read, then success.
    iREN = 1; iaddr = 32'h80; ramstate = RS_ERR;
    cycle();
    cycle();
    ramstate = RS_ACC; ramload = 32'hCAFEF00D;
    #1;
    chk1 ("t5 mem_err set", mem_err, 1'b1);
    chk32("t5 iload", iload, 32'hCAFEF00D);
    cycle();
    quiet();
    cycle();
    cycle();
    chk1("t5 mem_err sticky", mem_err, 1'b1);

    // Async reset in the middle of a dcache access.
    dREN = 1; daddr = 32'h500; ramstate = RS_BUSY;
    cycle();
    cycle();
    #3;
    nRST = 1'b0;
    #1;
    chk1 ("t6 ramREN", ramREN, 1'b0);
    chk1 ("t6 ramWEN", ramWEN, 1'b0);
    chk32("t6 ramaddr", ramaddr, 32'h0);
    chk1 ("t6 dwait", dwait, 1'b1);
    chk1 ("t6 mem_err", mem_err, 1'b0);
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    cycle();
    ramstate = RS_ACC; ramload = 32'h13572468;
    #1;
    chk1 ("t6 dwait after reset", dwait, 1'b0);
    chk32("t6 dload after reset", dload, 32'h13572468);
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      iREN     = ($urandom_range(0, 3) != 0);
      dREN     = ($urandom_range(0, 1) != 0);
      dWEN     = ($urandom_range(0, 3) == 0);
      iaddr    = $urandom;
      daddr    = $urandom;
      dstore   = $urandom;
      ramload  = $urandom;
      ramstate = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the data cache and the instruction cache; the single point through which both caches reach the shared RAM port.
- Arbitrates one word-sized RAM transaction at a time between dcache (read/write) and icache (read only).
- Returns per-cache wait and load data.
- Grants dcache by priority, with a starvation guard that forces an icache grant after a bounded run of dcache grants.

Parameters:
- STARVE_LIMIT, 4: max consecutive dcache grants while iREN is pending before icache is forced; range 1..15.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iload  out  32  icache read data
- iwait  out  1  icache wait; 0 marks transaction complete
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dload  out  32  dcache read data
- dwait  out  1  dcache wait; 0 marks transaction complete
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- mem_err  out  1  sticky; set on any ERROR seen during a granted access

Behaviour:
- Reset: state IDLE, starve_cnt=0, mem_err=0; iwait=dwait=1, all RAM outputs 0, iload=dload=0. Reset asserted mid-access aborts immediately; RAM enables drop asynchronously.
- States: IDLE, D_ACC, I_ACC.
- IDLE:
  - No RAM enables; both waits=1.
  - If iREN & starve_cnt==STARVE_LIMIT -> I_ACC.
  - Else if dREN|dWEN -> D_ACC.
  - Else if iREN -> I_ACC.
  - Else stay.
- D_ACC:
  - ramaddr=daddr, ramstore=dstore, ramREN=dREN, ramWEN=dWEN (dWEN wins; ramREN=dREN&~dWEN).
  - On ramstate==ACCESS: dwait=0 and dload=ramload in the same cycle, combinationally; next IDLE.
  - Otherwise dwait=1, stay.
  - If dREN|dWEN drops before ACCESS: next IDLE, no completion pulse.
- I_ACC:
  - ramaddr=iaddr, ramREN=1, ramWEN=0.
  - On ACCESS: iwait=0, iload=ramload; next IDLE.
  - If iREN drops: next IDLE.
- The non-granted cache always sees wait=1 and load=0.
- Minimum latency is 2 cycles per transaction: one IDLE cycle, then the grant cycle (if RAM returns ACCESS immediately). Each wait=0 pulse lasts exactly one cycle.
- starve_cnt (4 bits):
  - Increments, saturating at STARVE_LIMIT, on each D_ACC completion while iREN=1.
  - Clears on any I_ACC completion, or on a D_ACC completion while iREN=0.
- ERROR: treated as not-ACCESS (transaction keeps waiting); sets mem_err, cleared only by reset.
- Simultaneous dREN and dWEN: treated as a write.
- Requests are level-held by the caches; the arbiter never latches address or data.

Decomposition:
- arb_state_t {IDLE, D_ACC, I_ACC} goes in diaosi_types_pkg.
- ramstate_t and word_t come from cpu_types_pkg.
- Single module; no sub-module (the starvation counter is a few lines).
- The existing caches_if modports are reused for the cache-facing ports.

Test Plan:
- Reset, then dREN=1, daddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> dwait low for exactly one cycle on cycle 4, dload=0xDEADBEEF, iwait=1 throughout.
- dREN and iREN both held, RAM always ACCESS -> grants D,D,D,D,I with STARVE_LIMIT=4; starve_cnt reaches 4, then clears to 0 after the I grant.
- dWEN=1, daddr=0x3100, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramaddr=0x3100, ramstore=0x12345678 until ACCESS, then dwait=0.
- Grant D_ACC, drop dREN while RAM is BUSY -> return to IDLE, no dwait pulse, ramREN=0 the next cycle; a pending iREN is then granted.
- ramstate=ERROR for 1 cycle during I_ACC, then ACCESS -> mem_err=1 and stays 1, iwait pulses low once, iload correct.
- Assert nRST during D_ACC -> all RAM outputs 0 immediately, dwait=1, state IDLE; after release, a new request completes normally.
